// File: rtl/dmem_access_ctrl.sv
// Data memory port sequencer/arbiter: pipeline pass-through plus debug burst-dump engine.
// Latency: pipeline zero added cycles; debug word takes >=3 cycles (ISSUE, CAPTURE, HOLD).
// Backpressure: debug waits in ISSUE while the pipeline owns the port, holds in HOLD until i_dbg_ready.
// Optional starvation guard: define DMEM_ACCESS_STARVE_EN to force a debug grant after STARVE_LIMIT denials.
module dmem_access_ctrl #(
    parameter int NB_DEPTH     = 10,
    parameter int NB_DATA      = 32,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NB_DEPTH-1:0] i_pipe_addr,
    input  logic [NB_DATA-1:0]  i_pipe_data,
    input  logic [1:0]          i_pipe_we,
    input  logic [1:0]          i_pipe_re,
    output logic [NB_DATA-1:0]  o_pipe_data,
    output logic                o_pipe_stall,
    input  logic                i_dbg_start,
    input  logic [NB_DEPTH-1:0] i_dbg_base,
    input  logic [NB_DEPTH:0]   i_dbg_len,
    input  logic                i_dbg_ready,
    output logic [NB_DATA-1:0]  o_dbg_data,
    output logic                o_dbg_valid,
    output logic                o_dbg_busy,
    output logic                o_dbg_done,
    output logic [NB_DEPTH-1:0] o_mem_addr,
    output logic [NB_DATA-1:0]  o_mem_data,
    output logic [1:0]          o_mem_we,
    output logic [1:0]          o_mem_re,
    input  logic [NB_DATA-1:0]  i_mem_data
);

    // Memory access codes shared with the pipeline.
    localparam logic [1:0] WRITE_DISABLE = 2'b00;
    localparam logic [1:0] READ_DISABLE  = 2'b00;
    localparam logic [1:0] READ_WORD     = 2'b11;

`ifdef DMEM_ACCESS_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    localparam int                  SW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [NB_DEPTH:0]   REM_ONE = (NB_DEPTH + 1)'(1);
    localparam logic [NB_DEPTH-1:0] ADDR_ONE = NB_DEPTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [NB_DEPTH-1:0] addr_q;
    logic [NB_DEPTH:0]   rem_q;
    logic [NB_DATA-1:0]  data_q;
    logic [SW-1:0]       starve_cnt;

    logic pipe_req;
    logic starve_force;
    logic dbg_grant;

    assign pipe_req     = (i_pipe_we != WRITE_DISABLE) || (i_pipe_re != READ_DISABLE);
    // With the guard compiled out the count never moves, so this is constant low.
    assign starve_force = STARVE_EN && (starve_cnt == SW'(STARVE_LIMIT));
    // Reset gating keeps the memory port on the pipeline while reset is held.
    assign dbg_grant    = i_rst_n && (state == S_ISSUE) && (!pipe_req || starve_force);

    assign o_pipe_stall = STARVE_EN && dbg_grant && pipe_req;
    assign o_pipe_data  = i_mem_data;
    assign o_dbg_data   = data_q;
    assign o_dbg_valid  = (state == S_HOLD);
    assign o_dbg_done   = (state == S_DONE);
    assign o_dbg_busy   = (state != S_IDLE);

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the dump sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_dbg_start) begin
                    state_nxt = (i_dbg_len != '0) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                if (dbg_grant) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: state_nxt = S_HOLD;
            S_HOLD: begin
                if (i_dbg_ready) begin
                    state_nxt = (rem_q == REM_ONE) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Dump address/remaining counters, captured read word and starvation counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            addr_q     <= '0;
            rem_q      <= '0;
            data_q     <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_dbg_start) begin
                        addr_q <= i_dbg_base;
                        rem_q  <= i_dbg_len;
                    end
                end
                S_CAPTURE: data_q <= i_mem_data;
                S_HOLD: begin
                    if (i_dbg_ready) begin
                        rem_q  <= rem_q - REM_ONE;
                        addr_q <= addr_q + ADDR_ONE;
                    end
                end
                default: ;
            endcase
            if (STARVE_EN && (state == S_ISSUE) && !dbg_grant) begin
                starve_cnt <= starve_cnt + SW'(1);
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    // Memory port mux: debug read on grant, otherwise pipeline pass-through.
    always_comb begin
        o_mem_addr = i_pipe_addr;
        o_mem_data = i_pipe_data;
        o_mem_we   = i_pipe_we;
        o_mem_re   = i_pipe_re;
        if (dbg_grant) begin
            o_mem_addr = addr_q;
            o_mem_we   = WRITE_DISABLE;
            o_mem_re   = READ_WORD;
        end
    end

endmodule
